// File: rtl/uart_cmd_parser_pkg.sv
// Purpose: shared types and constants for the UART command-line parser.
//   - FSM state encoding
//   - ASCII constants used by the line assembler and decoder
//   - command strings and response lengths, plus the response ROM lookup
package uart_cmd_pkg;

  localparam int DEF_MAX_LEN = 8;

  typedef enum logic [1:0] {
    ST_RECV   = 2'd0,
    ST_DECODE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  localparam logic [23:0] CMD_RUN      = "RUN";
  localparam logic [31:0] CMD_STOP     = "STOP";
  localparam logic [39:0] CMD_CLEAR    = "CLEAR";
  localparam logic [39:0] CMD_MODE_PFX = {"MODE", ASCII_SP};

  localparam int RESP_OK_LEN  = 4;
  localparam int RESP_ERR_LEN = 5;

  // One bit per recognised command; at most one is ever set.
  typedef struct packed {
    logic mode;
    logic clear;
    logic stop;
    logic run;
  } cmd_t;

  // Response ROM: "OK\r\n" or "ERR\r\n"
  function automatic logic [7:0] resp_byte(input logic sel_err, input logic [2:0] idx);
    logic [7:0] b;
    b = ASCII_LF;
    if (sel_err) begin
      case (idx)
        3'd0:    b = "E";
        3'd1:    b = "R";
        3'd2:    b = "R";
        3'd3:    b = ASCII_CR;
        default: b = ASCII_LF;
      endcase
    end else begin
      case (idx)
        3'd0:    b = "O";
        3'd1:    b = "K";
        3'd2:    b = ASCII_CR;
        default: b = ASCII_LF;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Purpose: FIFO-side bus of the command parser.
//   rx_rdata/rx_empty/rx_rd : first-word fall-through RX FIFO read port
//   tx_wdata/tx_full/tx_wr  : TX FIFO write port
//   slave  = parser side, master = FIFO side
interface uart_cmd_parser_if;
  logic [7:0] rx_rdata;
  logic       rx_empty;
  logic       rx_rd;
  logic [7:0] tx_wdata;
  logic       tx_full;
  logic       tx_wr;

  modport master (
    output rx_rdata, rx_empty, tx_full,
    input  rx_rd, tx_wdata, tx_wr
  );

  modport slave (
    input  rx_rdata, rx_empty, tx_full,
    output rx_rd, tx_wdata, tx_wr
  );
endinterface

// File: rtl/uart_cmd_parser_resp_seq.sv
// Purpose: response byte sequencer; streams "OK\r\n" or "ERR\r\n" into the TX FIFO.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load a new response (sel_err chooses ERR), index back to 0
//   i_tx_full      : TX FIFO full, stalls the sequence without losing a byte
//   o_tx_wr        : TX push, o_tx_wdata the byte pushed
//   o_done         : high in the cycle the final byte is pushed
module uart_resp_seq
  import uart_cmd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_sel_err,
  input  logic       i_tx_full,
  output logic       o_tx_wr,
  output logic [7:0] o_tx_wdata,
  output logic       o_done
);

  logic       r_active;
  logic       r_err;
  logic [2:0] r_idx;
  logic [2:0] w_last;

  assign w_last     = r_err ? 3'(RESP_ERR_LEN - 1) : 3'(RESP_OK_LEN - 1);
  assign o_tx_wr    = r_active & ~i_tx_full;
  assign o_tx_wdata = resp_byte(r_err, r_idx);
  assign o_done     = o_tx_wr & (r_idx == w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_err    <= i_sel_err;
      r_idx    <= '0;
    end else if (o_tx_wr) begin
      r_active <= ~o_done;
      r_idx    <= o_done ? 3'd0 : r_idx + 3'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Purpose: ASCII command-line parser between the UART RX and TX FIFOs.
//   Assembles a CR/LF terminated line, decodes RUN / STOP / CLEAR / MODE d,
//   pulses the matching command output and answers "OK\r\n" or "ERR\r\n".
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   fifo            : RX/TX FIFO bus (slave side)
//   o_cmd_run/stop/clear/mode : one-cycle command pulses (first RESP cycle)
//   o_mode_val      : digit of the last accepted MODE command
//   o_busy          : high while decoding or answering
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  uart_cmd_parser_if.slave   fifo,
  output logic               o_cmd_run,
  output logic               o_cmd_stop,
  output logic               o_cmd_clear,
  output logic               o_cmd_mode,
  output logic [3:0]         o_mode_val,
  output logic               o_busy
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  state_t        r_state, w_state_next;
  logic [7:0]    r_buf [MAX_LEN];
  logic [LW-1:0] r_len;
  logic          r_ovf;
  cmd_t          r_cmd;
  logic [3:0]    r_mode_val;

  logic          w_pop;
  logic          w_is_term;
  logic [7:0]    w_byte;
  logic          w_store;
  cmd_t          w_cmd;
  logic          w_start;
  logic          w_done;

  assign w_pop     = (r_state == ST_RECV) & ~fifo.rx_empty;
  assign w_is_term = (fifo.rx_rdata == ASCII_CR) | (fifo.rx_rdata == ASCII_LF);
  assign w_byte    = ((fifo.rx_rdata >= 8'h61) && (fifo.rx_rdata <= 8'h7A)) ?
                     (fifo.rx_rdata & 8'hDF) : fifo.rx_rdata;
  assign w_store   = w_pop & ~w_is_term & (r_len < LEN_MAX);
  assign w_start   = (r_state == ST_DECODE);
  assign fifo.rx_rd = w_pop;

  // Line buffer contents need no reset: r_len qualifies every read.
  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_buf[r_len[IW-1:0]] <= w_byte;
    end
  end

  // Exact-length compare against the command table; overflow never matches.
  always_comb begin
    w_cmd = '0;
    if (!r_ovf) begin
      if ((r_len == LW'(3)) && ({r_buf[0], r_buf[1], r_buf[2]} == CMD_RUN))
        w_cmd.run = 1'b1;
      if ((r_len == LW'(4)) && ({r_buf[0], r_buf[1], r_buf[2], r_buf[3]} == CMD_STOP))
        w_cmd.stop = 1'b1;
      if ((r_len == LW'(5)) &&
          ({r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4]} == CMD_CLEAR))
        w_cmd.clear = 1'b1;
      if ((r_len == LW'(6)) &&
          ({r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4]} == CMD_MODE_PFX) &&
          (r_buf[5] >= ASCII_0) && (r_buf[5] <= ASCII_9))
        w_cmd.mode = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RECV: begin
        // A bare terminator (e.g. LF of a CRLF pair) is swallowed silently.
        if (w_pop && w_is_term && ((r_len != '0) || r_ovf))
          w_state_next = ST_DECODE;
      end
      ST_DECODE: w_state_next = ST_RESP;
      ST_RESP: begin
        if (w_done)
          w_state_next = ST_RECV;
      end
      default: w_state_next = ST_RECV;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RECV;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_cmd      <= '0;
      r_mode_val <= '0;
    end else begin
      r_state <= w_state_next;
      // Loaded only on the DECODE edge, so the pulse covers the first RESP cycle.
      r_cmd   <= w_start ? w_cmd : '0;
      if (w_start && w_cmd.mode)
        r_mode_val <= r_buf[5][3:0];  // low nibble of '0'..'9' is the digit
      if (w_store)
        r_len <= r_len + LW'(1);
      else if (w_pop && !w_is_term)
        r_ovf <= 1'b1;
      if (w_done) begin
        r_len <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  uart_resp_seq u_resp_seq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_start),
    .i_sel_err  (~(|w_cmd)),
    .i_tx_full  (fifo.tx_full),
    .o_tx_wr    (fifo.tx_wr),
    .o_tx_wdata (fifo.tx_wdata),
    .o_done     (w_done)
  );

  assign o_cmd_run   = r_cmd.run;
  assign o_cmd_stop  = r_cmd.stop;
  assign o_cmd_clear = r_cmd.clear;
  assign o_cmd_mode  = r_cmd.mode;
  assign o_mode_val  = r_mode_val;
  assign o_busy      = (r_state != ST_RECV);

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  typedef struct {
    bit         is_pulse;
    logic [7:0] val;
    logic [3:0] mode;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_parser_if ifc();

  logic       cmd_run, cmd_stop, cmd_clear, cmd_mode, busy;
  logic [3:0] mode_val;

  uart_cmd_parser dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .fifo       (ifc.slave),
    .o_cmd_run  (cmd_run),
    .o_cmd_stop (cmd_stop),
    .o_cmd_clear(cmd_clear),
    .o_cmd_mode (cmd_mode),
    .o_mode_val (mode_val),
    .o_busy     (busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          bytes_seen = 0;
  logic [3:0]  exp_mode = 4'd0;
  bit          full_force = 1'b0;
  bit          full_rand = 1'b0;
  byte unsigned rx_q[$];
  ev_t         exp_q[$];

  // Reference model state: the line as text plus an overflow flag.
  string       m_line = "";
  bit          m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_byte_ev(input logic [7:0] b);
    ev_t e;
    e.is_pulse = 1'b0; e.val = b; e.mode = 4'd0;
    exp_q.push_back(e);
  endtask

  task automatic model_line_done();
    logic [7:0] pv;
    logic [3:0] md;
    ev_t e;
    pv = 8'h00; md = 4'd0;
    if (!m_ovf) begin
      if (m_line == "RUN") pv = 8'h01;
      else if (m_line == "STOP") pv = 8'h02;
      else if (m_line == "CLEAR") pv = 8'h04;
      else if (m_line.len() == 6 && m_line.substr(0, 4) == "MODE " &&
               m_line[5] >= "0" && m_line[5] <= "9") begin
        pv = 8'h08;
        md = 4'(m_line[5] - 8'h30);
      end
    end
    if (pv != 8'h00) begin
      e.is_pulse = 1'b1; e.val = pv; e.mode = md;
      exp_q.push_back(e);
      push_byte_ev(8'h4F); push_byte_ev(8'h4B);
    end else begin
      push_byte_ev(8'h45); push_byte_ev(8'h52); push_byte_ev(8'h52);
    end
    push_byte_ev(8'h0D); push_byte_ev(8'h0A);
    m_line = "";
    m_ovf = 1'b0;
  endtask

  task automatic model_byte(input byte unsigned b);
    byte unsigned u;
    if (b == 8'h0D || b == 8'h0A) begin
      if (m_line.len() != 0 || m_ovf) model_line_done();
    end else begin
      u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;
      if (m_line.len() < 8) m_line = $sformatf("%s%c", m_line, u);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic send_b(input byte unsigned b);
    rx_q.push_back(b);
    model_byte(b);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) send_b(s[i]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 3000 && (rx_q.size() != 0 || exp_q.size() != 0 || busy !== 1'b0)) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s timeout: rx left %0d, expected events left %0d, busy %0b",
               name, rx_q.size(), exp_q.size(), busy);
    end
  endtask

  task automatic wait_bytes(input string name, input int target);
    int n;
    n = 0;
    while (n < 300 && bytes_seen < target) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s wait: bytes seen %0d, required %0d", name, bytes_seen, target);
    end
  endtask

  // RX FIFO and TX-full model: pops take effect just after the consuming edge.
  initial begin : driver
    bit s_rd;
    ifc.rx_empty = 1'b1;
    ifc.rx_rdata = 8'h00;
    ifc.tx_full  = 1'b0;
    forever begin
      @(negedge clk);
      s_rd = ifc.rx_rd;
      @(posedge clk); #1;
      if (s_rd && rx_q.size() > 0) void'(rx_q.pop_front());
      ifc.rx_empty = (rx_q.size() == 0);
      ifc.rx_rdata = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      ifc.tx_full  = full_rand ? ($urandom_range(0, 3) == 0) : full_force;
    end
  end

  // Monitor: every pulse cycle and every TX push is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    ev_t e;
    logic [3:0] pv;
    if (rst_n) begin
      pv = {cmd_mode, cmd_clear, cmd_stop, cmd_run};
      if (pv != 4'd0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got %0h, expected none", pv);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 32'(e.is_pulse), 32'd1);
          check("pulse_vec", 32'(pv), 32'(e.val[3:0]));
          if (e.is_pulse && e.val[3]) exp_mode = e.mode;
          check("mode_val_at_pulse", 32'(mode_val), 32'(exp_mode));
          check("pulse_busy", 32'(busy), 32'd1);
          if (!ifc.tx_full) check("pulse_with_first_byte", 32'(ifc.tx_wr), 32'd1);
        end
      end
      if (ifc.tx_wr) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx: got %0h, expected none", ifc.tx_wdata);
        end else begin
          e = exp_q.pop_front();
          $display("tx byte %02h expected %02h%s", ifc.tx_wdata, e.val,
                   e.is_pulse ? " (pulse due)" : "");
          check("tx_kind", 32'(e.is_pulse), 32'd0);
          check("tx_byte", 32'(ifc.tx_wdata), 32'(e.val));
        end
      end
      if (ifc.rx_rd) check("rx_rd_while_busy", 32'(busy), 32'd0);
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    string cands[10];
    string s;
    byte unsigned c;
    int r;
    cands = '{"RUN", "STOP", "CLEAR", "MODE 3", "MODE 9", "MODEX", "MODE A",
              "RUN ", "HELLOWORLD1", "STOPP"};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_rx_rd", 32'(ifc.rx_rd), 32'd0);
    check("reset_tx_wr", 32'(ifc.tx_wr), 32'd0);
    check("reset_pulses", 32'({cmd_run, cmd_stop, cmd_clear, cmd_mode}), 32'd0);
    check("reset_mode_val", 32'(mode_val), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    $display("txn: RUN CR");
    send("RUN"); send_b(8'h0D);
    wait_idle("run");

    $display("txn: mode 7 CR LF");
    send("mode 7"); send_b(8'h0D); send_b(8'h0A);
    wait_idle("mode7");
    check("mode_held", 32'(mode_val), 32'd7);

    $display("txn: MODEX CR, HELLOWORLD1 CR");
    send("MODEX"); send_b(8'h0D);
    send("HELLOWORLD1"); send_b(8'h0D);
    wait_idle("err_pair");
    check("mode_unchanged", 32'(mode_val), 32'd7);

    $display("txn: STOP CR with tx_full held 20 cycles");
    send("STOP"); send_b(8'h0D);
    wait_bytes("stop_first", bytes_seen + 1);
    #2;
    full_force = 1'b1;
    send("RUN"); send_b(8'h0D);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_rx_rd", 32'(ifc.rx_rd), 32'd0);
      check("hold_tx_wr", 32'(ifc.tx_wr), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #2;
    full_force = 1'b0;
    wait_idle("stop_hold");

    $display("txn: CLEAR CR aborted by reset");
    send("CLEAR"); send_b(8'h0D);
    wait_bytes("clear_first", bytes_seen + 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx_wr", 32'(ifc.tx_wr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pulses", 32'({cmd_run, cmd_stop, cmd_clear, cmd_mode}), 32'd0);
    check("abort_mode_val", 32'(mode_val), 32'd0);
    exp_q.delete();
    rx_q.delete();
    m_line = "";
    m_ovf = 1'b0;
    exp_mode = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    $display("txn: RUN CR after reset");
    send("RUN"); send_b(8'h0D);
    wait_idle("run_after_reset");

    $display("txn: RUN CR STOP CR back to back");
    send("RUN"); send_b(8'h0D); send("STOP"); send_b(8'h0D);
    wait_idle("back_to_back");

    // Randomised lines with random case, terminators and TX backpressure.
    full_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        s = "";
        r = $urandom_range(0, 10);
        for (int k = 0; k < r; k++) begin
          c = 8'($urandom_range(32, 126));
          s = $sformatf("%s%c", s, c);
        end
      end else begin
        s = cands[$urandom_range(0, 9)];
      end
      for (int k = 0; k < s.len(); k++)
        if (s[k] >= "A" && s[k] <= "Z" && $urandom_range(0, 1) == 1) s[k] = s[k] + 8'd32;
      $display("txn: random line \"%s\"", s);
      send(s);
      r = $urandom_range(0, 2);
      if (r != 1) send_b(8'h0D);
      if (r != 0) send_b(8'h0A);
      if ($urandom_range(0, 3) == 0) wait_idle("random_chunk");
    end
    wait_idle("random_end");
    full_rand = 1'b0;
    @(posedge clk); #2;
    check("final_mode_val", 32'(mode_val), 32'(exp_mode));
    check("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
